// File: rtl/riscv_pkg.sv
// Shared RV decode definitions: opcodes, instruction-format encoding, decoded fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  // Major opcodes recognised by the decode stage
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Bit positions inside the one-hot format vector
  localparam int TYPE_R_BIT = 0;
  localparam int TYPE_I_BIT = 1;
  localparam int TYPE_S_BIT = 2;
  localparam int TYPE_B_BIT = 3;
  localparam int TYPE_U_BIT = 4;
  localparam int TYPE_J_BIT = 5;

  // One-hot instruction format; IT_NONE marks an illegal encoding
  typedef enum logic [5:0] {
    IT_NONE = 6'b000000,
    IT_R    = 6'b000001,
    IT_I    = 6'b000010,
    IT_S    = 6'b000100,
    IT_B    = 6'b001000,
    IT_U    = 6'b010000,
    IT_J    = 6'b100000
  } instr_type_e;

  // Width-independent part of a decoded bundle; pc/imm are added per XLEN in the stage
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] itype;
    logic       illegal;
  } dec_fields_t;

endpackage

// File: rtl/id_stage_if.sv
// Upstream instruction and downstream decoded-bundle handshake of the ID stage.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; flush travels with the bus.
interface id_stage_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [5:0]      out_type;
  logic            out_illegal;

  // Environment side: feeds instructions, consumes bundles
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_type, out_illegal
  );

  // Stage side
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/id_decode.sv
// Combinational RV instruction decode: format, register fields, sign-extended immediate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module id_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0] instr,
  output dec_fields_t     fields,
  output logic [XLEN-1:0] imm
);

  instr_type_e        itype;
  logic signed [31:0] imm32;

  // Classify the format from the opcode; non-32-bit encodings are illegal
  always_comb begin
    itype = IT_NONE;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OP_OP, OP_AMO:                        itype = IT_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  itype = IT_I;
        OP_STORE:                             itype = IT_S;
        OP_BRANCH:                            itype = IT_B;
        OP_LUI, OP_AUIPC:                     itype = IT_U;
        OP_JAL:                               itype = IT_J;
        default:                              itype = IT_NONE;
      endcase
    end
  end

  // Extract only the fields the format uses; everything else stays zero
  always_comb begin
    fields         = '0;
    imm32          = '0;
    fields.itype   = itype;
    fields.illegal = (itype == IT_NONE);
    case (itype)
      IT_R: begin
        fields.opcode = instr[6:0];
        fields.rd     = instr[11:7];
        fields.funct3 = instr[14:12];
        fields.rs1    = instr[19:15];
        fields.rs2    = instr[24:20];
        fields.funct7 = instr[31:25];
      end
      IT_I: begin
        fields.opcode = instr[6:0];
        fields.rd     = instr[11:7];
        fields.funct3 = instr[14:12];
        fields.rs1    = instr[19:15];
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      IT_S: begin
        fields.opcode = instr[6:0];
        fields.funct3 = instr[14:12];
        fields.rs1    = instr[19:15];
        fields.rs2    = instr[24:20];
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      IT_B: begin
        fields.opcode = instr[6:0];
        fields.funct3 = instr[14:12];
        fields.rs1    = instr[19:15];
        fields.rs2    = instr[24:20];
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      IT_U: begin
        fields.opcode = instr[6:0];
        fields.rd     = instr[11:7];
        imm32 = {instr[31:12], 12'b0};
      end
      IT_J: begin
        fields.opcode = instr[6:0];
        fields.rd     = instr[11:7];
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // imm32 is signed, so the size cast sign-extends for XLEN=64 (U included)
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// ID pipeline stage: decodes before registering into an output register plus one skid entry.
// Latency: 1 cycle from acceptance to out_valid when the output register is empty or draining.
// Backpressure: in_ready = !skid_valid (registered); flush drops everything and wins over transfers.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,   // 32 or 64
  parameter int ILEN = 32    // only 32 supported
) (
  input  logic       clk,
  input  logic       rst_n,
  id_stage_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_fields_t     f;
  } bundle_t;

  dec_fields_t     dec_f;
  logic [XLEN-1:0] dec_imm;
  bundle_t         dec_b;
  bundle_t         out_q;
  bundle_t         skid_q;
  logic            out_valid_q;
  logic            skid_valid_q;
  logic            accept;
  logic            out_free;

  id_decode #(.XLEN(XLEN), .ILEN(ILEN)) u_decode (
    .instr  (bus.in_instr),
    .fields (dec_f),
    .imm    (dec_imm)
  );

  assign dec_b    = '{pc: bus.in_pc, imm: dec_imm, f: dec_f};
  assign accept   = bus.in_valid && !skid_valid_q;
  assign out_free = !out_valid_q || bus.out_ready;

  // Output/skid buffer: refill output from skid first to keep order, park in skid on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec_b;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec_b;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_opcode  = out_q.f.opcode;
  assign bus.out_rd      = out_q.f.rd;
  assign bus.out_rs1     = out_q.f.rs1;
  assign bus.out_rs2     = out_q.f.rs2;
  assign bus.out_funct3  = out_q.f.funct3;
  assign bus.out_funct7  = out_q.f.funct7;
  assign bus.out_type    = out_q.f.itype;
  assign bus.out_illegal = out_q.f.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector tables for XLEN 32/64 plus skid, flush and reset sequences.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: driven explicitly through out_ready in the hand-written sequences.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32), .ILEN(32)) b32 ();
  id_stage_if #(.XLEN(64), .ILEN(32)) b64 ();

  id_stage #(.XLEN(32), .ILEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  id_stage #(.XLEN(64), .ILEN(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [5:0]  typ;
    logic        ill;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] seen32[$];

  // Record every downstream transfer of the 32-bit instance
  always @(posedge clk)
    if (b32.out_valid && b32.out_ready) seen32.push_back(b32.out_pc);

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    b32.in_valid = v;
    b32.in_instr = instr;
    b32.in_pc    = pc;
  endtask

  vec_t v32[11];
  vec_t v64[3];
  logic [31:0] pc32;
  logic [63:0] pc64;

  initial begin
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b0;
    b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1'b0;

    //            instr          opc    rd  rs1 rs2 f3  f7     imm                     type       ill
    v32[0]  = '{32'hFFF00093, 7'h13, 1,  0,  0,  0,  7'h00, 64'hFFFFFFFF_FFFFFFFF, 6'b000010, 1'b0}; // addi x1,x0,-1
    v32[1]  = '{32'hFE112E23, 7'h23, 0,  2,  1,  2,  7'h00, 64'hFFFFFFFF_FFFFFFFC, 6'b000100, 1'b0}; // sw x1,-4(x2)
    v32[2]  = '{32'hFF9FF06F, 7'h6F, 0,  0,  0,  0,  7'h00, 64'hFFFFFFFF_FFFFFFF8, 6'b100000, 1'b0}; // jal x0,-8
    v32[3]  = '{32'h402081B3, 7'h33, 3,  1,  2,  0,  7'h20, 64'h0,                 6'b000001, 1'b0}; // sub x3,x1,x2
    v32[4]  = '{32'hFE208EE3, 7'h63, 0,  1,  2,  0,  7'h00, 64'hFFFFFFFF_FFFFFFFC, 6'b001000, 1'b0}; // beq x1,x2,-4
    v32[5]  = '{32'h00812283, 7'h03, 5,  2,  0,  2,  7'h00, 64'h8,                 6'b000010, 1'b0}; // lw x5,8(x2)
    v32[6]  = '{32'h12345397, 7'h17, 7,  0,  0,  0,  7'h00, 64'h12345000,          6'b010000, 1'b0}; // auipc x7
    v32[7]  = '{32'h00000073, 7'h73, 0,  0,  0,  0,  7'h00, 64'h0,                 6'b000010, 1'b0}; // ecall
    v32[8]  = '{32'h00000000, 7'h00, 0,  0,  0,  0,  7'h00, 64'h0,                 6'b000000, 1'b1};
    v32[9]  = '{32'h0000007F, 7'h00, 0,  0,  0,  0,  7'h00, 64'h0,                 6'b000000, 1'b1};
    v32[10] = '{32'hFFFFFFFD, 7'h00, 0,  0,  0,  0,  7'h00, 64'h0,                 6'b000000, 1'b1}; // low bits 01

    v64[0]  = '{32'h800002B7, 7'h37, 5,  0,  0,  0,  7'h00, 64'hFFFFFFFF_80000000, 6'b010000, 1'b0}; // lui x5,0x80000
    v64[1]  = '{32'h123452B7, 7'h37, 5,  0,  0,  0,  7'h00, 64'h00000000_12345000, 6'b010000, 1'b0};
    v64[2]  = '{32'hFF9FF06F, 7'h6F, 0,  0,  0,  0,  7'h00, 64'hFFFFFFFF_FFFFFFF8, 6'b100000, 1'b0};

    // Reset state
    #12;
    check("reset32", {b32.out_valid, b32.in_ready, b32.out_pc, b32.out_imm, b32.out_opcode, b32.out_rd,
                      b32.out_type, b32.out_illegal}, {1'b0, 1'b1, 32'h0, 32'h0, 7'h0, 5'h0, 6'h0, 1'b0});
    check("reset64", {b64.out_valid, b64.in_ready, b64.out_pc, b64.out_imm, b64.out_type},
                     {1'b0, 1'b1, 64'h0, 64'h0, 6'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back decode table, XLEN=32
    b32.out_ready = 1'b1;
    foreach (v32[i]) begin
      pc32 = 32'h1000 + 32'(i * 4);
      drive32(1'b1, v32[i].instr, pc32);
      step();
      check($sformatf("dec32_%0d", i),
            {b32.in_ready, b32.out_valid, b32.out_pc, b32.out_opcode, b32.out_rd, b32.out_rs1, b32.out_rs2,
             b32.out_funct3, b32.out_funct7, b32.out_imm, b32.out_type, b32.out_illegal},
            {1'b1, 1'b1, pc32, v32[i].opc, v32[i].rd, v32[i].rs1, v32[i].rs2,
             v32[i].f3, v32[i].f7, v32[i].imm[31:0], v32[i].typ, v32[i].ill});
    end
    drive32(1'b0, 32'h0, 32'h0);
    step();
    check("drain32", {31'h0, b32.out_valid}, 32'h0);

    // Decode table, XLEN=64
    b64.out_ready = 1'b1;
    foreach (v64[i]) begin
      pc64 = 64'h80000000_00001000 + 64'(i * 4);
      @(negedge clk);
      b64.in_valid = 1'b1; b64.in_instr = v64[i].instr; b64.in_pc = pc64;
      step();
      check($sformatf("dec64_%0d", i),
            {b64.out_valid, b64.out_pc, b64.out_opcode, b64.out_rd, b64.out_rs1, b64.out_rs2,
             b64.out_funct3, b64.out_funct7, b64.out_imm, b64.out_type, b64.out_illegal},
            {1'b1, pc64, v64[i].opc, v64[i].rd, v64[i].rs1, v64[i].rs2,
             v64[i].f3, v64[i].f7, v64[i].imm, v64[i].typ, v64[i].ill});
    end
    @(negedge clk);
    b64.in_valid = 1'b0;

    // Skid: A,B,C with 3 stalled cycles, then release
    drive32(1'b0, 32'h0, 32'h0);
    seen32.delete();
    b32.out_ready = 1'b0;
    drive32(1'b1, 32'hFFF00093, 32'h2000);              // A
    step();
    check("skid_a_out", {b32.out_valid, b32.in_ready, b32.out_pc}, {1'b1, 1'b1, 32'h2000});
    drive32(1'b1, 32'hFE112E23, 32'h2004);              // B
    step();
    check("skid_b_in", {b32.out_valid, b32.in_ready, b32.out_pc}, {1'b1, 1'b0, 32'h2000});
    drive32(1'b1, 32'hFF9FF06F, 32'h2008);              // C, must wait
    step();
    check("skid_hold", {b32.in_ready, b32.out_pc, b32.out_imm, b32.out_type, b32.out_rd},
                       {1'b0, 32'h2000, 32'hFFFFFFFF, 6'b000010, 5'd1});
    @(negedge clk);
    b32.out_ready = 1'b1;
    step();
    check("skid_rel_b", {b32.out_valid, b32.in_ready, b32.out_pc, b32.out_imm},
                        {1'b1, 1'b1, 32'h2004, 32'hFFFFFFFC});
    step();
    check("skid_rel_c", {b32.out_valid, b32.out_pc, b32.out_imm}, {1'b1, 32'h2008, 32'hFFFFFFF8});
    drive32(1'b0, 32'h0, 32'h0);
    step();
    check("skid_empty", {31'h0, b32.out_valid}, 32'h0);
    check("skid_count", 256'(seen32.size()), 256'd3);
    if (seen32.size() == 3)
      check("skid_order", {seen32[0], seen32[1], seen32[2]}, {32'h2000, 32'h2004, 32'h2008});

    // Flush with skid full and input valid; then flush into an empty stage
    seen32.delete();
    b32.out_ready = 1'b0;
    drive32(1'b1, 32'h00812283, 32'h3000);
    step();
    drive32(1'b1, 32'h402081B3, 32'h3004);
    step();
    check("flush_full", {30'h0, b32.out_valid, b32.in_ready}, {30'h0, 1'b1, 1'b0});
    drive32(1'b1, 32'h12345397, 32'h3008);
    b32.flush = 1'b1;
    step();
    check("flush_clr", {30'h0, b32.out_valid, b32.in_ready}, {30'h0, 1'b0, 1'b1});
    drive32(1'b1, 32'h00000073, 32'h300C);               // flush still high: dropped
    step();
    check("flush_drop", {30'h0, b32.out_valid, b32.in_ready}, {30'h0, 1'b0, 1'b1});
    drive32(1'b0, 32'h0, 32'h0);
    b32.flush = 1'b0;
    b32.out_ready = 1'b1;
    repeat (3) step();
    check("flush_ghost", 256'(seen32.size()), 256'd0);

    // Reset asserted with both entries held
    b32.out_ready = 1'b0;
    drive32(1'b1, 32'hFFF00093, 32'h4000);
    step();
    drive32(1'b1, 32'hFE112E23, 32'h4004);
    step();
    @(negedge clk);
    b32.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid", {b32.out_valid, b32.in_ready, b32.out_pc}, {1'b0, 1'b1, 32'h0});
    seen32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    b32.out_ready = 1'b1;
    repeat (3) step();
    check("rst_ghost", {b32.out_valid, 32'(seen32.size())}, {1'b0, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
